uart_rx_engine: RTL

Serial receive engine for the UART receiver path. It detects the start bit on `serial_in` and samples 5, 7 or 8 data bits LSB-first at mid-bit, using the APB-programmed `bit_period` and `data_size`. It then checks the stop bit and presents the byte, MSB-aligned, to the APB slave. It sits directly upstream of the APB slave and drives its `rx_data`, `data_ready`, `overrun_error` and `framing_error` inputs. It consumes the slave's `data_read` pulse.

---
 rtl/uart_rx_pkg.sv | 30 +++
 rtl/rx_bit_timer.sv | 60 ++++++
 rtl/uart_rx_engine.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared types and constants for the UART receive engine
// Contents: rx_state_t FSM encoding, supported frame sizes, line idle level,
//           and decode_size() which maps an unsupported size onto 8 bits.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START_CHK,
    DATA,
    STOP,
    LOAD
  } rx_state_t;

  localparam logic [3:0] SIZE_5 = 4'd5;
  localparam logic [3:0] SIZE_7 = 4'd7;
  localparam logic [3:0] SIZE_8 = 4'd8;

  localparam logic IDLE_LEVEL = 1'b1;

  function automatic logic [3:0] decode_size(input logic [3:0] ds);
    logic [3:0] n;
    case (ds)
      SIZE_5:  n = SIZE_5;
      SIZE_7:  n = SIZE_7;
      default: n = SIZE_8;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/rx_bit_timer.sv
// rtl/rx_bit_timer.sv - mid-bit sample tick generator for the UART receive engine
// Ports:
//   clk, n_rst        clock, asynchronous active-low reset
//   start             frame start (cycle 0): latch period, load half period
//   active            engine is inside a frame and wants sample ticks
//   period [13:0]     clamped clocks per bit, latched on start
//   half   [13:0]     half bit period, first countdown after start
//   sample_tick       one-cycle pulse on each sample cycle
//   sample_idx [3:0]  index of the sample at the tick: 0 start, 1..N data, N+1 stop
module rx_bit_timer (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        start,
  input  logic        active,
  input  logic [13:0] period,
  input  logic [13:0] half,
  output logic        sample_tick,
  output logic [3:0]  sample_idx
);

  logic [13:0] cnt_q, cnt_d;
  logic [13:0] period_q, period_d;
  logic [3:0]  idx_q, idx_d;

  // Loaded with H-1 on cycle 0 so the tick lands exactly on cycle H,
  // then reloaded with P-1 so later ticks land every P cycles.
  always_comb begin
    cnt_d    = cnt_q;
    period_d = period_q;
    idx_d    = idx_q;
    if (start) begin
      period_d = period;
      cnt_d    = half - 14'd1;
      idx_d    = 4'd0;
    end else if (active) begin
      if (cnt_q == 14'd0) begin
        cnt_d = period_q - 14'd1;
        idx_d = idx_q + 4'd1;
      end else begin
        cnt_d = cnt_q - 14'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q    <= '0;
      period_q <= '0;
      idx_q    <= '0;
    end else begin
      cnt_q    <= cnt_d;
      period_q <= period_d;
      idx_q    <= idx_d;
    end
  end

  assign sample_tick = active && (cnt_q == 14'd0);
  assign sample_idx  = idx_q;

endmodule

// File: rtl/uart_rx_engine.sv
// rtl/uart_rx_engine.sv - UART serial receive engine feeding the APB slave
// Optional feature macro: UART_RX_SYNC_EN (two-flop input synchronizer).
// Ports:
//   clk, n_rst          clock, asynchronous active-low reset
//   serial_in           UART line, idles high
//   data_size [3:0]     bits per frame 5/7/8, anything else is 8
//   bit_period [13:0]   clocks per bit, clamped up to MIN_PERIOD
//   data_read           one-cycle pulse when the slave reads rx_data
//   rx_data [7:0]       received byte, MSB-aligned
//   data_ready          unread byte held
//   overrun_error       an unread byte was overwritten
//   framing_error       last frame had a 0 stop bit
module uart_rx_engine
  import uart_rx_pkg::*;
#(
  parameter int MIN_PERIOD = 10
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        serial_in,
  input  logic [3:0]  data_size,
  input  logic [13:0] bit_period,
  input  logic        data_read,
  output logic [7:0]  rx_data,
  output logic        data_ready,
  output logic        overrun_error,
  output logic        framing_error
);

  localparam logic [13:0] MIN_P = 14'(MIN_PERIOD);

  logic rx_in;

`ifdef UART_RX_SYNC_EN
  logic sync1_q, sync1_d, sync2_q, sync2_d;
  assign sync1_d = serial_in;
  assign sync2_d = sync1_q;
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync1_q <= IDLE_LEVEL;
      sync2_q <= IDLE_LEVEL;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end
  assign rx_in = sync2_q;
`else
  assign rx_in = serial_in;
`endif

  rx_state_t   state_q, state_d;
  logic        rx_prev_q, rx_prev_d;
  logic [3:0]  size_q, size_d;
  logic [7:0]  shift_q, shift_d;
  logic        stop_q, stop_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        ready_q, ready_d;
  logic        ovr_q, ovr_d;
  logic        fe_q, fe_d;

  logic        start_det;
  logic        active;
  logic [13:0] period_clamped;
  logic        sample_tick;
  logic [3:0]  sample_idx;

  assign rx_prev_d      = rx_in;
  assign start_det      = (state_q == IDLE) && rx_prev_q && !rx_in;
  assign active         = (state_q == START_CHK) || (state_q == DATA) || (state_q == STOP);
  assign period_clamped = (bit_period < MIN_P) ? MIN_P : bit_period;

  rx_bit_timer u_timer (
    .clk         (clk),
    .n_rst       (n_rst),
    .start       (start_det),
    .active      (active),
    .period      (period_clamped),
    .half        (period_clamped >> 1),
    .sample_tick (sample_tick),
    .sample_idx  (sample_idx)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (start_det) state_d = START_CHK;
      START_CHK: if (sample_tick) state_d = rx_in ? IDLE : DATA;
      // sample_idx equals the data bit number (1-based) on a DATA tick
      DATA:      if (sample_tick && (sample_idx == size_q)) state_d = STOP;
      STOP:      if (sample_tick) state_d = LOAD;
      LOAD:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    size_d    = size_q;
    shift_d   = shift_q;
    stop_d    = stop_q;
    rx_data_d = rx_data_q;
    ready_d   = ready_q;
    ovr_d     = ovr_q;
    fe_d      = fe_q;
    if (start_det) begin
      size_d  = decode_size(data_size);
      shift_d = 8'h00;
    end
    // Right shift with the new bit at bit 7 leaves a short frame MSB-aligned.
    if ((state_q == DATA) && sample_tick) shift_d = {rx_in, shift_q[7:1]};
    if ((state_q == STOP) && sample_tick) stop_d = rx_in;
    if (state_q == LOAD) begin
      if (stop_q) begin
        // A read in the load cycle consumes the old byte, so the new one
        // is not an overrun and the stale overrun flag is cleared.
        rx_data_d = shift_q;
        ready_d   = 1'b1;
        fe_d      = 1'b0;
        if (ready_q && !data_read) ovr_d = 1'b1;
        else if (data_read)        ovr_d = 1'b0;
      end else begin
        fe_d = 1'b1;
      end
    end else if (data_read) begin
      ready_d = 1'b0;
      ovr_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rx_prev_q <= IDLE_LEVEL;
      size_q    <= SIZE_8;
      shift_q   <= 8'h00;
      stop_q    <= 1'b0;
      rx_data_q <= 8'h00;
      ready_q   <= 1'b0;
      ovr_q     <= 1'b0;
      fe_q      <= 1'b0;
    end else begin
      rx_prev_q <= rx_prev_d;
      size_q    <= size_d;
      shift_q   <= shift_d;
      stop_q    <= stop_d;
      rx_data_q <= rx_data_d;
      ready_q   <= ready_d;
      ovr_q     <= ovr_d;
      fe_q      <= fe_d;
    end
  end

  assign rx_data       = rx_data_q;
  assign data_ready    = ready_q;
  assign overrun_error = ovr_q;
  assign framing_error = fe_q;

endmodule
